// File: rtl/spi_ram_responder_pkg.sv
// Shared constants for the SPI serial-SRAM responder: opcodes, the SPI
// address width and the FSM state encoding.
package spi_ram_pkg;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam int         SPI_ADDR_W = 16;

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CMD     = 3'd1;
  localparam logic [2:0] ADDR    = 3'd2;
  localparam logic [2:0] RD_DATA = 3'd3;
  localparam logic [2:0] WR_DATA = 3'd4;
  localparam logic [2:0] IGNORE  = 3'd5;

endpackage

// File: rtl/spi_ram_responder_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with rise/fall pulses
// derived from the last two synchronized samples.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the raw input through the synchronizer and keep one extra sample
  // so edges can be detected on the settled value.
  // NOTE: sequential state uses non-blocking assignments so every flop in the
  // chain samples the value its neighbour held before this clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = chain[STAGES-1] & ~prev;
  assign fall  = ~chain[STAGES-1] & prev;

endmodule

// File: rtl/spi_ram_responder.sv
// SPI mode-0 responder emulating a 23LC-style sequential SRAM (READ 0x03,
// WRITE 0x02, 16-bit address, auto-increment). SCK/CS/MOSI are oversampled
// with clk; the byte array can be preloaded through a backdoor port.
module spi_ram_responder
  import spi_ram_pkg::*;
#(
  parameter int MEM_AW      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [7:0]        load_data,
  output logic              busy,
  output logic              cmd_err
);

  localparam int DEPTH = 1 << MEM_AW;

  logic cs_level, cs_fall, cs_rise_unused;
  logic sck_level_unused, sck_rise, sck_fall;
  logic mosi_level, mosi_rise_unused, mosi_fall_unused;

  logic [2:0]            state;
  logic [3:0]            bit_cnt;
  logic [SPI_ADDR_W-1:0] shift;
  logic                  rd_mode;
  logic [MEM_AW-1:0]     addr;
  logic [7:0]            tx_byte;
  logic [2:0]            tx_idx;
  logic [7:0]            mem [DEPTH];

  logic [SPI_ADDR_W-1:0] shift_in;
  logic [MEM_AW-1:0]     spi_addr;
  logic [MEM_AW-1:0]     addr_next;
  logic                  wr_en;
  logic [7:0]            wr_data;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
    .clk(clk), .rst(rst), .d(spi_cs),
    .level(cs_level), .rise(cs_rise_unused), .fall(cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(clk), .rst(rst), .d(spi_sck),
    .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(spi_mosi),
    .level(mosi_level), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  // MOSI is captured on the same clk edge that sees SCK rise.
  assign shift_in  = {shift[SPI_ADDR_W-2:0], mosi_level};
  assign spi_addr  = shift_in[MEM_AW-1:0];
  assign addr_next = addr + MEM_AW'(1);
  assign wr_data   = shift_in[7:0];
  assign wr_en     = (state == WR_DATA) && !cs_level && sck_rise && (bit_cnt == 4'd7);

  // Transaction FSM: CS high aborts from any state and wins over a
  // coincident SCK edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      shift       <= '0;
      rd_mode     <= 1'b0;
      addr        <= '0;
      tx_byte     <= '0;
      tx_idx      <= '0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      cmd_err <= 1'b0;
      if (cs_level) begin
        state       <= IDLE;
        bit_cnt     <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
              busy    <= 1'b1;
            end
          end
          CMD: begin
            if (sck_rise) begin
              shift <= shift_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                if (shift_in[7:0] == CMD_READ) begin
                  rd_mode <= 1'b1;
                  state   <= ADDR;
                end else if (shift_in[7:0] == CMD_WRITE) begin
                  rd_mode <= 1'b0;
                  state   <= ADDR;
                end else begin
                  state   <= IGNORE;
                  cmd_err <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          ADDR: begin
            if (sck_rise) begin
              shift <= shift_in;
              if (bit_cnt == 4'd15) begin
                bit_cnt <= '0;
                addr    <= spi_addr;
                if (rd_mode) begin
                  tx_byte     <= mem[spi_addr];
                  tx_idx      <= 3'd7;
                  spi_miso_oe <= 1'b1;
                  state       <= RD_DATA;
                end else begin
                  state <= WR_DATA;
                end
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          RD_DATA: begin
            if (sck_fall) begin
              spi_miso <= tx_byte[tx_idx];
            end
            if (sck_rise) begin
              if (tx_idx == 3'd0) begin
                addr    <= addr_next;
                tx_byte <= mem[addr_next];
                tx_idx  <= 3'd7;
              end else begin
                tx_idx <= tx_idx - 3'd1;
              end
            end
          end
          WR_DATA: begin
            if (sck_rise) begin
              shift <= shift_in;
              if (bit_cnt == 4'd7) begin
                bit_cnt <= '0;
                addr    <= addr_next;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          IGNORE: begin
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Byte array: SPI write, then backdoor load, so the load wins on a clash.
  // NOTE: the array has no reset; preloaded contents must survive rst, and a
  // reset on a memory would also stop it mapping onto RAM resources.
  // NOTE: two non-blocking writes to the same element in one cycle resolve to
  // the later statement, which gives the backdoor priority.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= wr_data;
    end
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

endmodule

// File: tb/tb_spi_ram_responder.sv
// Directed bench for spi_ram_responder: reads, writes, wrap, bad opcode,
// partial write abort and reset in the middle of a transaction.
`timescale 1ns/1ps
module tb_spi_ram_responder;
  import spi_ram_pkg::*;

  localparam int MEM_AW = 8;
  localparam int SYNC   = 2;
  localparam int HALF   = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              spi_cs;
  logic              spi_sck;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_miso_oe;
  logic              load_en;
  logic [MEM_AW-1:0] load_addr;
  logic [7:0]        load_data;
  logic              busy;
  logic              cmd_err;

  int checks = 0;
  int errors = 0;
  int err_cnt = 0;

  logic [7:0] rd_buf [8];
  logic [7:0] rd_oe_addr;
  logic [7:0] rd_oe_data;

  spi_ram_responder #(.MEM_AW(MEM_AW), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst),
    .spi_cs(spi_cs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .busy(busy), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (cmd_err === 1'b1) err_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_byte(input logic [7:0] a, input logic [7:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic xfer_bit(input logic b, output logic m, output logic oe);
    spi_mosi = b;
    wait_clk(HALF);
    m  = spi_miso;
    oe = spi_miso_oe;
    spi_sck = 1'b1;
    wait_clk(HALF);
    spi_sck = 1'b0;
  endtask

  task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx, output logic [7:0] oem);
    logic m, o;
    for (int i = 7; i >= 0; i--) begin
      xfer_bit(tx[i], m, o);
      rx[i]  = m;
      oem[i] = o;
    end
  endtask

  task automatic cs_begin();
    spi_cs = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic cs_end();
    spi_cs = 1'b1;
    wait_clk(HALF);
  endtask

  task automatic spi_read(input logic [15:0] a, input int n);
    logic [7:0] rx, oem;
    cs_begin();
    xfer_byte(CMD_READ, rx, oem);
    rd_oe_addr = oem;
    xfer_byte(a[15:8], rx, oem);
    rd_oe_addr |= oem;
    xfer_byte(a[7:0], rx, oem);
    rd_oe_addr |= oem;
    rd_oe_data = 8'hFF;
    for (int i = 0; i < n; i++) begin
      xfer_byte(8'h00, rx, oem);
      rd_buf[i] = rx;
      rd_oe_data &= oem;
    end
    cs_end();
  endtask

  task automatic test_reset();
    rst = 1'b1; spi_cs = 1'b1; spi_sck = 1'b0; spi_mosi = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    wait_clk(5);
    rst = 1'b0;
    wait_clk(4);
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", spi_miso); end
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", spi_miso_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", cmd_err); end
  endtask

  task automatic test_read();
    load_byte(8'h10, 8'hA5);
    load_byte(8'h11, 8'h3C);
    spi_read(16'h0010, 2);
    checks++; if (rd_buf[0] !== 8'hA5) begin errors++; $display("FAIL read_byte0: got %h want a5", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h3C) begin errors++; $display("FAIL read_byte1: got %h want 3c", rd_buf[1]); end
    checks++; if (rd_oe_addr !== 8'h00) begin errors++; $display("FAIL read_oe_cmd_addr: got %h want 00", rd_oe_addr); end
    checks++; if (rd_oe_data !== 8'hFF) begin errors++; $display("FAIL read_oe_data: got %h want ff", rd_oe_data); end
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL read_oe_after_cs: got %b want 0", spi_miso_oe); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL read_busy_after_cs: got %b want 0", busy); end
  endtask

  task automatic test_write();
    logic [7:0] rx, oem;
    load_byte(8'h22, 8'h77);
    cs_begin();
    xfer_byte(CMD_WRITE, rx, oem);
    xfer_byte(8'h00, rx, oem);
    xfer_byte(8'h20, rx, oem);
    xfer_byte(8'hDE, rx, oem);
    xfer_byte(8'hAD, rx, oem);
    checks++; if (oem !== 8'h00) begin errors++; $display("FAIL write_oe: got %h want 00", oem); end
    cs_end();
    spi_read(16'h0020, 3);
    checks++; if (rd_buf[0] !== 8'hDE) begin errors++; $display("FAIL write_rb0: got %h want de", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'hAD) begin errors++; $display("FAIL write_rb1: got %h want ad", rd_buf[1]); end
    checks++; if (rd_buf[2] !== 8'h77) begin errors++; $display("FAIL write_untouched_22: got %h want 77", rd_buf[2]); end
  endtask

  task automatic test_wrap();
    load_byte(8'hFF, 8'h11);
    load_byte(8'h00, 8'h22);
    load_byte(8'h01, 8'h33);
    spi_read(16'h00FF, 3);
    checks++; if (rd_buf[0] !== 8'h11) begin errors++; $display("FAIL wrap_ff: got %h want 11", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h22) begin errors++; $display("FAIL wrap_00: got %h want 22", rd_buf[1]); end
    checks++; if (rd_buf[2] !== 8'h33) begin errors++; $display("FAIL wrap_01: got %h want 33", rd_buf[2]); end
    spi_read(16'h12FF, 2);
    checks++; if (rd_buf[0] !== 8'h11) begin errors++; $display("FAIL alias_12ff: got %h want 11", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h22) begin errors++; $display("FAIL alias_wrap: got %h want 22", rd_buf[1]); end
  endtask

  task automatic test_bad_cmd();
    logic [7:0] op, rx, oem, miso_or, oe_or;
    logic m, o;
    int base, lat, hi;
    op = 8'h9F;
    base = err_cnt;
    cs_begin();
    for (int i = 7; i >= 1; i--) xfer_bit(op[i], m, o);
    spi_mosi = op[0];
    wait_clk(HALF);
    spi_sck = 1'b1;
    lat = -1; hi = 0;
    for (int k = 1; k <= HALF; k++) begin
      @(negedge clk);
      if (cmd_err === 1'b1) begin
        hi++;
        if (lat < 0) lat = k;
      end
    end
    spi_sck = 1'b0;
    checks++; if (lat != SYNC + 1) begin errors++; $display("FAIL bad_cmd_latency: got %0d want %0d", lat, SYNC + 1); end
    checks++; if (hi != 1) begin errors++; $display("FAIL bad_cmd_width: got %0d want 1", hi); end
    miso_or = 8'h00; oe_or = 8'h00;
    for (int j = 0; j < 2; j++) begin
      xfer_byte(8'hFF, rx, oem);
      miso_or |= rx;
      oe_or   |= oem;
    end
    checks++; if (miso_or !== 8'h00) begin errors++; $display("FAIL bad_cmd_miso: got %h want 00", miso_or); end
    checks++; if (oe_or !== 8'h00) begin errors++; $display("FAIL bad_cmd_oe: got %h want 00", oe_or); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bad_cmd_busy: got %b want 1", busy); end
    cs_end();
    checks++; if (err_cnt - base != 1) begin errors++; $display("FAIL bad_cmd_pulses: got %0d want 1", err_cnt - base); end
    spi_read(16'h0010, 2);
    checks++; if (rd_buf[0] !== 8'hA5) begin errors++; $display("FAIL after_bad_rd0: got %h want a5", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h3C) begin errors++; $display("FAIL after_bad_rd1: got %h want 3c", rd_buf[1]); end
  endtask

  task automatic test_partial_write();
    logic [7:0] rx, oem;
    logic m, o;
    int n;
    load_byte(8'h30, 8'h5A);
    cs_begin();
    xfer_byte(CMD_WRITE, rx, oem);
    xfer_byte(8'h00, rx, oem);
    xfer_byte(8'h30, rx, oem);
    for (int i = 0; i < 5; i++) xfer_bit(1'b1, m, o);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL partial_busy_before: got %b want 1", busy); end
    spi_cs = 1'b1;
    n = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (n < 0 && busy === 1'b0) n = k;
    end
    checks++; if (n < 1 || n > SYNC + 1) begin errors++; $display("FAIL partial_busy_clear: got %0d cycles want 1..%0d", n, SYNC + 1); end
    spi_read(16'h0030, 1);
    checks++; if (rd_buf[0] !== 8'h5A) begin errors++; $display("FAIL partial_mem30: got %h want 5a", rd_buf[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] rx, oem, oe_or;
    logic m, o;
    cs_begin();
    xfer_byte(CMD_READ, rx, oem);
    xfer_byte(8'h00, rx, oem);
    for (int i = 0; i < 3; i++) xfer_bit(1'b0, m, o);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    checks++; if (spi_miso_oe !== 1'b0) begin errors++; $display("FAIL rstmid_oe: got %b want 0", spi_miso_oe); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL rstmid_miso: got %b want 0", spi_miso); end
    checks++; if (cmd_err !== 1'b0) begin errors++; $display("FAIL rstmid_cmd_err: got %b want 0", cmd_err); end
    rst = 1'b0;
    oe_or = 8'h00;
    for (int i = 0; i < 5; i++) begin
      xfer_bit(1'b1, m, o);
      oe_or[0] = oe_or[0] | o;
    end
    xfer_byte(8'h00, rx, oem);
    oe_or |= oem;
    checks++; if (oe_or !== 8'h00) begin errors++; $display("FAIL rstmid_no_resume_oe: got %h want 00", oe_or); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_no_resume_busy: got %b want 0", busy); end
    cs_end();
    spi_read(16'h0010, 2);
    checks++; if (rd_buf[0] !== 8'hA5) begin errors++; $display("FAIL rstmid_rd0: got %h want a5", rd_buf[0]); end
    checks++; if (rd_buf[1] !== 8'h3C) begin errors++; $display("FAIL rstmid_rd1: got %h want 3c", rd_buf[1]); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_wrap();
    test_bad_cmd();
    test_partial_write();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
